regfile_wport_ctrl: RTL

Write-port controller for the 32-entry integer register file. Sequences a post-reset clear sweep of x1..x31, then shares the file's single write port between two requesters. Requester 0 is core writeback and has priority. Requester 1 is a long-latency unit (load/multiply), protected by a starvation counter. Sits directly in front of the register file's `d_reg_wen_i`/`d_rd_i`/`d_valWB_i` inputs.

---
 rtl/rf_ctrl_pkg.sv | 14 +
 rtl/rf_clear_seq.sv | 41 ++++
 rtl/regfile_wport_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register file write-port controller.
// Used by regfile_wport_ctrl and rf_clear_seq.
package rf_ctrl_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_e;

   localparam int NUM_REGS     = 32;
   localparam int DEF_MAX_WAIT = 4;
   localparam int STARVE_W     = 4;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sweep index generator for x1..x31.
// Only built when RF_CLEAR_ON_RESET_EN is defined.
`ifdef RF_CLEAR_ON_RESET_EN
module rf_clear_seq
   import rf_ctrl_pkg::*;
#(
   parameter int REG_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [REG_WIDTH-1:0] clr_idx_o,
   output logic                 last_o
);

   logic [REG_WIDTH-1:0] idx_q, idx_d;
   logic                 done_q, done_d;

   assign clr_idx_o = idx_q;
   assign last_o    = !done_q && (idx_q == REG_WIDTH'(NUM_REGS - 1));

   always_comb begin
      idx_d  = idx_q;
      done_d = done_q;
      if (!done_q) begin
         if (last_o) done_d = 1'b1;
         else        idx_d  = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= REG_WIDTH'(1);
         done_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         done_q <= done_d;
      end
   end

endmodule
`endif

// File: rtl/regfile_wport_ctrl.sv
// Register file write-port arbiter: r0 priority, r1 starvation guard.
// RF_CLEAR_ON_RESET_EN adds a post-reset x1..x31 clear sweep.
module regfile_wport_ctrl
   import rf_ctrl_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int REG_WIDTH = 5,
   parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 r0_valid_i,
   input  logic [REG_WIDTH-1:0] r0_rd_i,
   input  logic [WIDTH-1:0]     r0_data_i,
   output logic                 r0_ready_o,
   input  logic                 r1_valid_i,
   input  logic [REG_WIDTH-1:0] r1_rd_i,
   input  logic [WIDTH-1:0]     r1_data_i,
   output logic                 r1_ready_o,
   output logic                 rf_wen_o,
   output logic [REG_WIDTH-1:0] rf_rd_o,
   output logic [WIDTH-1:0]     rf_data_o,
   output logic                 init_done_o
);

   logic [STARVE_W-1:0]  starve_q, starve_d;
   logic [REG_WIDTH-1:0] clr_idx;
   logic                 in_clear;

`ifdef RF_CLEAR_ON_RESET_EN
   rf_state_e state_q, state_d;
   logic      clr_last;

   rf_clear_seq #(
      .REG_WIDTH (REG_WIDTH)
   ) u_clear_seq (
      .clk       (clk),
      .rst       (rst),
      .clr_idx_o (clr_idx),
      .last_o    (clr_last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CLEAR:   if (clr_last) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= CLEAR;
      else     state_q <= state_d;
   end

   assign in_clear = (state_q == CLEAR);
`else
   assign clr_idx  = '0;
   assign in_clear = 1'b0;
`endif

   logic w0, w1, z0, z1, g0, g1, force1;

   always_comb begin
      // rd==0 requests are acked but never take the port
      z0     = r0_valid_i && (r0_rd_i == '0);
      z1     = r1_valid_i && (r1_rd_i == '0);
      w0     = r0_valid_i && (r0_rd_i != '0);
      w1     = r1_valid_i && (r1_rd_i != '0);
      force1 = w1 && (starve_q == STARVE_W'(MAX_WAIT));
      g1     = w1 && (force1 || !w0);
      g0     = w0 && !g1;

      r0_ready_o  = 1'b0;
      r1_ready_o  = 1'b0;
      rf_wen_o    = 1'b0;
      rf_rd_o     = '0;
      rf_data_o   = '0;
      init_done_o = 1'b0;
      starve_d    = '0;

      if (!rst) begin
         if (in_clear) begin
            rf_wen_o = 1'b1;
            rf_rd_o  = clr_idx;
         end else begin
            init_done_o = 1'b1;
            r0_ready_o  = z0 || g0;
            r1_ready_o  = z1 || g1;
            if (g1) begin
               rf_wen_o  = 1'b1;
               rf_rd_o   = r1_rd_i;
               rf_data_o = r1_data_i;
            end else if (g0) begin
               rf_wen_o  = 1'b1;
               rf_rd_o   = r0_rd_i;
               rf_data_o = r0_data_i;
            end
            if (r1_valid_i && !r1_ready_o) begin
               if (starve_q == STARVE_W'(MAX_WAIT)) starve_d = starve_q;
               else starve_d = starve_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end

endmodule
